// File: rtl/regex_ctx_pkg.sv
// Shared types and helpers for the regex stream context manager.
//   sid_width : stream-ID width for a given stream count (minimum 1 bit)
//   sid_t / state_t / cnt_t : bus types for the default configuration
//   sat_inc   : saturating increment against an explicit maximum
package regex_ctx_pkg;

    localparam int unsigned STATE_W_DEF     = 11;
    localparam int unsigned NUM_STREAMS_DEF = 64;
    localparam int unsigned CNT_W_DEF       = 16;

    function automatic int unsigned sid_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SID_W_DEF = sid_width(NUM_STREAMS_DEF);

    typedef logic [SID_W_DEF-1:0]   sid_t;
    typedef logic [STATE_W_DEF-1:0] state_t;
    typedef logic [CNT_W_DEF-1:0]   cnt_t;

    // Counters are carried in a 32-bit container; callers cast to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ctx_state_ram.sv
// Saved engine-state storage: 1 write / 1 read port, synchronous, no reset.
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i         : read request; rdata_o valid the following cycle
// A same-address read and write returns the old contents.
module ctx_state_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 11,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream context manager for one DFA regex engine.
// Saves engine state per stream at packet end and restores it at packet start,
// tracks the per-packet match flag, and keeps saturating per-stream and total
// match counters with a host read port.
//   Parser side : stream_id, new_stream_id, load_state, eop, enable
//   Engine side : eng_state_out, eng_accept -> eng_state_in, eng_state_vld, fired
//   Host side   : rd_en, rd_sid -> rd_count, rd_vld; total_count
// Build option: REGEX_CTX_CLEAR_ON_READ_EN makes counter reads destructive
// (total_count is never cleared).
module regex_stream_ctx
    import regex_ctx_pkg::*;
#(
    parameter  int unsigned STATE_W     = 11,
    parameter  int unsigned NUM_STREAMS = 64,
    parameter  int unsigned CNT_W       = 16,
    parameter  int unsigned RESET_STATE = 0,
    localparam int unsigned SID_W       = sid_width(NUM_STREAMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               load_state,
    input  logic               eop,
    input  logic               enable,
    input  logic [STATE_W-1:0] eng_state_out,
    input  logic               eng_accept,
    output logic [STATE_W-1:0] eng_state_in,
    output logic               eng_state_vld,
    output logic               fired,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [CNT_W-1:0]   rd_count,
    output logic               rd_vld,
    output logic [CNT_W-1:0]   total_count
);

    localparam logic [31:0]        CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [STATE_W-1:0] RST_ST  = STATE_W'(RESET_STATE);

    logic                   save_c;
    logic                   inc_c;
    logic [STATE_W-1:0]     ram_rdata;

    logic                   load_q;
    logic                   use_rst_q;
    logic                   byp_q;
    logic [STATE_W-1:0]     byp_data_q;
    logic                   fired_q, fired_d;
    logic [NUM_STREAMS-1:0] saved_vld_q;
    logic [CNT_W-1:0]       cnt_q [NUM_STREAMS];
    logic [CNT_W-1:0]       cnt_d [NUM_STREAMS];
    logic [CNT_W-1:0]       total_q, total_d;
    logic                   rd_vld_q;
    logic [CNT_W-1:0]       rd_count_q;

    // Closing a packet with the regex enabled saves state and may count a match.
    assign save_c = eop & enable;
    assign inc_c  = save_c & (fired_q | eng_accept);

    ctx_state_ram #(
        .DEPTH (NUM_STREAMS),
        .WIDTH (STATE_W),
        .AW    (SID_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (save_c),
        .waddr_i (stream_id),
        .wdata_i (eng_state_out),
        .re_i    (load_state),
        .raddr_i (stream_id),
        .rdata_o (ram_rdata)
    );

    // Match flag: eop without enable or a new packet clears, accept always wins.
    always_comb begin
        fired_d = fired_q;
        if (eop && !enable) fired_d = 1'b0;
        if (load_state)     fired_d = 1'b0;
        if (eng_accept)     fired_d = 1'b1;
    end

    // Counter update: optional read-clear first so a coincident increment lands on top.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
`ifdef REGEX_CTX_CLEAR_ON_READ_EN
        if (rd_en) cnt_d[rd_sid] = '0;
`endif
        if (inc_c) begin
            cnt_d[stream_id] = CNT_W'(sat_inc(32'(cnt_d[stream_id]), CNT_MAX));
            total_d          = CNT_W'(sat_inc(32'(total_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_q      <= 1'b0;
            use_rst_q   <= 1'b0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
            fired_q     <= 1'b0;
            saved_vld_q <= '0;
            cnt_q       <= '{default: '0};
            total_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            load_q <= load_state;
            if (load_state) begin
                // A save in the same cycle counts as "saved" and is forwarded past the RAM.
                use_rst_q  <= new_stream_id | ~(saved_vld_q[stream_id] | save_c);
                byp_q      <= save_c;
                byp_data_q <= eng_state_out;
            end
            fired_q <= fired_d;
            if (save_c) saved_vld_q[stream_id] <= 1'b1;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            rd_vld_q <= rd_en;
            if (rd_en) rd_count_q <= cnt_q[rd_sid];
        end
    end

    // Restore mux selects among flopped sources; driven to zero outside the strobe.
    always_comb begin
        eng_state_in = '0;
        if (load_q) begin
            if (use_rst_q)  eng_state_in = RST_ST;
            else if (byp_q) eng_state_in = byp_data_q;
            else            eng_state_in = ram_rdata;
        end
    end

    assign eng_state_vld = load_q;
    assign fired         = fired_q;
    assign rd_vld        = rd_vld_q;
    assign rd_count      = rd_count_q;
    assign total_count   = total_q;

endmodule

// File: tb/tb_regex_stream_ctx.sv
module tb_regex_stream_ctx;

    localparam int unsigned STATE_W     = 11;
    localparam int unsigned NUM_STREAMS = 64;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SID_W       = 6;
`ifdef REGEX_CTX_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               load_state;
    logic               eop;
    logic               enable;
    logic [STATE_W-1:0] eng_state_out;
    logic               eng_accept;
    logic [STATE_W-1:0] eng_state_in;
    logic               eng_state_vld;
    logic               fired;
    logic               rd_en;
    logic [SID_W-1:0]   rd_sid;
    logic [CNT_W-1:0]   rd_count;
    logic               rd_vld;
    logic [CNT_W-1:0]   total_count;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_st_q[$];
    logic [31:0] exp_rd_q[$];

    regex_stream_ctx #(
        .STATE_W     (STATE_W),
        .NUM_STREAMS (NUM_STREAMS),
        .CNT_W       (CNT_W),
        .RESET_STATE (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .load_state    (load_state),
        .eop           (eop),
        .enable        (enable),
        .eng_state_out (eng_state_out),
        .eng_accept    (eng_accept),
        .eng_state_in  (eng_state_in),
        .eng_state_vld (eng_state_vld),
        .fired         (fired),
        .rd_en         (rd_en),
        .rd_sid        (rd_sid),
        .rd_count      (rd_count),
        .rd_vld        (rd_vld),
        .total_count   (total_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; pulse inputs drop after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        load_state    = 1'b0;
        eop           = 1'b0;
        enable        = 1'b0;
        new_stream_id = 1'b0;
        eng_accept    = 1'b0;
        rd_en         = 1'b0;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_state_vld) begin
                if (exp_st_q.size() == 0) check("spurious eng_state_vld", 32'(eng_state_vld), 32'd0);
                else                      check("eng_state_in", 32'(eng_state_in), exp_st_q.pop_front());
            end
            if (rd_vld) begin
                if (exp_rd_q.size() == 0) check("spurious rd_vld", 32'(rd_vld), 32'd0);
                else                      check("rd_count", 32'(rd_count), exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stream_id = '0; new_stream_id = 1'b0; load_state = 1'b0;
        eop = 1'b0; enable = 1'b0; eng_state_out = '0; eng_accept = 1'b0;
        rd_en = 1'b0; rd_sid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset fired", 32'(fired), 32'd0);
        check("reset eng_state_vld", 32'(eng_state_vld), 32'd0);
        check("reset eng_state_in", 32'(eng_state_in), 32'd0);
        check("reset rd_vld", 32'(rd_vld), 32'd0);
        check("reset rd_count", 32'(rd_count), 32'd0);
        check("reset total_count", 32'(total_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // New stream starts from the reset state
        stream_id = 6'd5; new_stream_id = 1'b1; load_state = 1'b1; exp_st_q.push_back(32'd0); tick();
        check("fired after load", 32'(fired), 32'd0);

        // Save then restore stream 5; stream 6 never saved
        stream_id = 6'd5; eop = 1'b1; enable = 1'b1; eng_state_out = 11'h1A3; tick();
        stream_id = 6'd5; load_state = 1'b1; exp_st_q.push_back(32'h1A3); tick();
        stream_id = 6'd6; load_state = 1'b1; exp_st_q.push_back(32'd0); tick();

        // Save and restore of stream 7 in one cycle forwards the written value
        stream_id = 6'd7; eop = 1'b1; enable = 1'b1; eng_state_out = 11'h055;
        load_state = 1'b1; exp_st_q.push_back(32'h055); tick();

        // Counting on stream 3: accept inside packet
        stream_id = 6'd3; load_state = 1'b1; new_stream_id = 1'b1; exp_st_q.push_back(32'd0); tick();
        eng_accept = 1'b1; tick();
        check("fired on accept", 32'(fired), 32'd1);
        stream_id = 6'd3; eop = 1'b1; enable = 1'b1; eng_state_out = 11'h033; tick();
        check("total after pkt1", 32'(total_count), 32'd1);
        check("fired kept after enabled eop", 32'(fired), 32'd1);

        // Accept only in the eop cycle
        stream_id = 6'd3; load_state = 1'b1; exp_st_q.push_back(32'h033); tick();
        check("fired cleared by load", 32'(fired), 32'd0);
        stream_id = 6'd3; eop = 1'b1; enable = 1'b1; eng_accept = 1'b1; eng_state_out = 11'h033; tick();
        check("total after pkt2", 32'(total_count), 32'd2);
        check("fired after eop accept", 32'(fired), 32'd1);

        // Disabled eop: no count; fired follows accept
        stream_id = 6'd3; load_state = 1'b1; exp_st_q.push_back(32'h033); tick();
        eng_accept = 1'b1; tick();
        stream_id = 6'd3; eop = 1'b1; enable = 1'b0; tick();
        check("fired after disabled eop", 32'(fired), 32'd0);
        check("total after disabled eop", 32'(total_count), 32'd2);
        stream_id = 6'd3; eop = 1'b1; enable = 1'b0; eng_accept = 1'b1; tick();
        check("fired disabled eop with accept", 32'(fired), 32'd1);
        check("total disabled eop with accept", 32'(total_count), 32'd2);

        // load_state and eop together: previous packet counted with pre-clear fired
        stream_id = 6'd3; eop = 1'b1; enable = 1'b1; load_state = 1'b1; eng_state_out = 11'h044;
        exp_st_q.push_back(32'h044); tick();
        check("fired after eop+load", 32'(fired), 32'd0);
        check("total after eop+load", 32'(total_count), 32'd3);
        rd_sid = 6'd3; rd_en = 1'b1; exp_rd_q.push_back(32'd3); tick();

        // Back-to-back reads
        rd_sid = 6'd5; rd_en = 1'b1; exp_rd_q.push_back(32'd0); tick();
        rd_sid = 6'd3; rd_en = 1'b1; exp_rd_q.push_back(CLR ? 32'd0 : 32'd3); tick();

        // Stream 2 up to 4, then read colliding with an increment
        for (int i = 0; i < 4; i++) begin
            stream_id = 6'd2; eop = 1'b1; enable = 1'b1; eng_accept = 1'b1; tick();
        end
        check("total before collision", 32'(total_count), 32'd7);
        stream_id = 6'd2; eop = 1'b1; enable = 1'b1; eng_accept = 1'b1;
        rd_sid = 6'd2; rd_en = 1'b1; exp_rd_q.push_back(32'd4); tick();
        rd_sid = 6'd2; rd_en = 1'b1; exp_rd_q.push_back(CLR ? 32'd1 : 32'd5); tick();
        check("total after collision", 32'(total_count), 32'd8);

        // Saturation
        for (int i = 0; i < 17; i++) begin
            stream_id = 6'd2; eop = 1'b1; enable = 1'b1; eng_accept = 1'b1; tick();
        end
        rd_sid = 6'd2; rd_en = 1'b1; exp_rd_q.push_back(32'd15); tick();
        check("total saturated", 32'(total_count), 32'd15);

        // Reset in the middle of a packet
        stream_id = 6'd9; load_state = 1'b1; new_stream_id = 1'b1; exp_st_q.push_back(32'd0); tick();
        eng_accept = 1'b1; tick();
        check("fired before mid reset", 32'(fired), 32'd1);
        rst_n = 1'b0; tick(); tick();
        check("mid reset fired", 32'(fired), 32'd0);
        check("mid reset total", 32'(total_count), 32'd0);
        check("mid reset eng_state_vld", 32'(eng_state_vld), 32'd0);
        rst_n = 1'b1; tick(); tick();
        check("no strobe after reset", 32'(eng_state_vld), 32'd0);
        // Saved-valid bits are gone: stream 5 restarts from the reset state
        stream_id = 6'd5; load_state = 1'b1; exp_st_q.push_back(32'd0); tick();
        rd_sid = 6'd2; rd_en = 1'b1; exp_rd_q.push_back(32'd0); tick();

        repeat (4) tick();
        check("restore expectations drained", 32'(exp_st_q.size()), 32'd0);
        check("read expectations drained", 32'(exp_rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
